dfswt_readout: RTL and testbench

Window controller and magnitude readout placed directly after a pair of `dfswt_stage` correlators (I: count start offset points/4, Q: second instance offset by a quarter period). It gates sample strobes into the stages, counts a window of WINDOW samples and captures both accumulators at window end. It then clears the stages and emits a magnitude estimate (alpha-max-beta-min, alpha=1, beta=1/2) with the raw I/Q values over a valid/ready handshake.

---
 rtl/dfswt_pkg.sv | 12 +
 rtl/dfswt_mag.sv | 65 ++++++
 rtl/dfswt_readout.sv | 102 ++++++++++
 tb/tb_dfswt_readout.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dfswt_pkg.sv
// Shared types and widths for the dfswt correlator readout.
package dfswt_pkg;

  localparam int ACC_W = 32;
  localparam int MAG_W = ACC_W + 1;

  typedef enum logic {
    ACCUM   = 1'b0,
    CAPTURE = 1'b1
  } state_e;

endpackage

// File: rtl/dfswt_mag.sv
// Abs / max-min pipeline for the dfswt readout. Two registered stages here; the final
// add is presented combinationally and registered by the top's output register.
module dfswt_mag #(
  parameter int ACC_W = dfswt_pkg::ACC_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [ACC_W-1:0] in_i,
  input  logic signed [ACC_W-1:0] in_q,
  output logic                    res_valid,
  output logic        [ACC_W:0]   res_mag,
  output logic signed [ACC_W-1:0] res_i,
  output logic signed [ACC_W-1:0] res_q
);

  logic        [ACC_W-1:0] abs_i, abs_q;
  logic                    s1_valid, s2_valid;
  logic        [ACC_W-1:0] s1_abs_i, s1_abs_q, s2_max, s2_min;
  logic signed [ACC_W-1:0] s1_i, s1_q, s2_i, s2_q;

  // The most negative value wraps onto 2^(ACC_W-1), which fits the unsigned width.
  always_comb begin
    abs_i = in_i[ACC_W-1] ? -in_i : in_i;
    abs_q = in_q[ACC_W-1] ? -in_q : in_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_abs_i <= '0;
      s1_abs_q <= '0;
      s1_i     <= '0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      s2_max   <= '0;
      s2_min   <= '0;
      s2_i     <= '0;
      s2_q     <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_abs_i <= abs_i;
        s1_abs_q <= abs_q;
        s1_i     <= in_i;
        s1_q     <= in_q;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_max <= (s1_abs_i >= s1_abs_q) ? s1_abs_i : s1_abs_q;
        s2_min <= (s1_abs_i >= s1_abs_q) ? s1_abs_q : s1_abs_i;
        s2_i   <= s1_i;
        s2_q   <= s1_q;
      end
    end
  end

  always_comb begin
    res_valid = s2_valid;
    res_mag   = {1'b0, s2_max} + {2'b00, s2_min[ACC_W-1:1]};
    res_i     = s2_i;
    res_q     = s2_q;
  end

endmodule

// File: rtl/dfswt_readout.sv
// Window controller for a pair of dfswt_stage correlators: gates samples, captures the
// accumulators at window end, clears the stages and hands out a magnitude estimate.
module dfswt_readout #(
  parameter int WINDOW  = 8,
  parameter int CNTBITS = 3,
  parameter int ACC_W   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [ACC_W-1:0] acc_q,
  output logic                    stage_enable,
  output logic                    stage_clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [ACC_W:0]   out_mag,
  output logic signed [ACC_W-1:0] out_i,
  output logic signed [ACC_W-1:0] out_q,
  output logic                    drop,
  output logic                    overrun
);

  import dfswt_pkg::*;

  state_e                  state_q, state_d;
  logic      [CNTBITS-1:0] count_q, count_d;
  logic                    capture;
  logic                    res_valid;
  logic        [ACC_W:0]   res_mag;
  logic signed [ACC_W-1:0] res_i, res_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    stage_enable = 1'b0;
    stage_clear  = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      ACCUM: begin
        stage_enable = sample_valid;
        if (sample_valid) begin
          if (count_q == CNTBITS'(WINDOW - 1)) begin
            count_d = '0;
            state_d = CAPTURE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      CAPTURE: begin
        stage_clear = 1'b1;
        capture     = 1'b1;
        state_d     = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    if (reset) stage_enable = 1'b0;
  end

  dfswt_mag #(
    .ACC_W(ACC_W)
  ) u_mag (
    .clock    (clock),
    .reset    (reset),
    .in_valid (capture),
    .in_i     (acc_i),
    .in_q     (acc_q),
    .res_valid(res_valid),
    .res_mag  (res_mag),
    .res_i    (res_i),
    .res_q    (res_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ACCUM;
      count_q   <= '0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_i     <= '0;
      out_q     <= '0;
      drop      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (sample_valid && (state_q == CAPTURE)) drop <= 1'b1;
      // A fresh result always wins over an accept on the same edge.
      if (res_valid) begin
        out_valid <= 1'b1;
        out_mag   <= res_mag;
        out_i     <= res_i;
        out_q     <= res_q;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dfswt_readout.sv
// Scoreboard bench for dfswt_readout: stimulus pushes expected results, a monitor pops
// and compares on every accepted output.
module tb_dfswt_readout;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               sample_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [31:0] acc_i = '0;
  logic signed [31:0] acc_q = '0;
  logic               stage_enable, stage_clear, out_valid, drop, overrun;
  logic        [32:0] out_mag;
  logic signed [31:0] out_i, out_q;

  typedef struct {
    logic        [32:0] mag;
    logic signed [31:0] i;
    logic signed [31:0] q;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   en_pulses = 0;
  int   clr_pulses = 0;
  logic rdy = 1'b0;

  localparam logic signed [31:0] MinV = 32'sh8000_0000;

  dfswt_readout #(
    .WINDOW (8),
    .CNTBITS(3),
    .ACC_W  (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_valid(sample_valid),
    .acc_i       (acc_i),
    .acc_q       (acc_q),
    .stage_enable(stage_enable),
    .stage_clear (stage_clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mag     (out_mag),
    .out_i       (out_i),
    .out_q       (out_q),
    .drop        (drop),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic expect_result(input logic [32:0] m, input logic signed [31:0] i,
                               input logic signed [31:0] q);
    exp_t e;
    e.mag = m;
    e.i   = i;
    e.q   = q;
    sb.push_back(e);
  endtask

  // One clock cycle with the given sample_valid; returns at that cycle's falling edge.
  task automatic step(input logic sv);
    @(posedge clock);
    #1;
    sample_valid = sv;
    out_ready    = rdy;
    @(negedge clock);
    if (stage_enable) en_pulses++;
    if (stage_clear) clr_pulses++;
  endtask

  task automatic window(input logic signed [31:0] ai, input logic signed [31:0] aq,
                        input int gap, input logic cap_sv);
    for (int s = 0; s < 8; s++) begin
      step(1'b1);
      if (s == 0) begin
        acc_i = ai;
        acc_q = aq;
      end
      if (s < 7) repeat (gap) step(1'b0);
    end
    step(cap_sv);
    chk("stage_clear_in_capture", stage_clear, 1);
    chk("stage_enable_in_capture", stage_enable, 0);
  endtask

  task automatic wait_out(input string name, input int maxc);
    logic got;
    got = 1'b0;
    for (int k = 0; k < maxc && !got; k++) begin
      step(1'b0);
      got = out_valid;
    end
    chk(name, got, 1);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset        = 1'b1;
    sample_valid = 1'b1;
    rdy          = 1'b0;
    out_ready    = 1'b0;
    @(negedge clock);
    chk("enable_forced_low_in_reset", stage_enable, 0);
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mag", out_mag, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_drop", drop, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_stage_clear", stage_clear, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got mag=%0h i=%0d q=%0d, want none", out_mag, out_i,
                 out_q);
      end else begin
        mon_e = sb.pop_front();
        chk("out_mag", out_mag, mon_e.mag);
        chk("out_i", out_i, mon_e.i);
        chk("out_q", out_q, mon_e.q);
      end
    end
  end

  initial begin
    do_reset();

    // Continuous samples: fixed latency, one-cycle clear, sample lost in capture.
    rdy        = 1'b1;
    clr_pulses = 0;
    expect_result(33'd550, 32'sd300, -32'sd400);
    window(32'sd300, -32'sd400, 0, 1'b1);
    step(1'b0);
    chk("drop_continuous", drop, 1);
    chk("latency_t2", out_valid, 0);
    step(1'b0);
    chk("latency_t3", out_valid, 0);
    step(1'b0);
    chk("latency_t4", out_valid, 1);
    step(1'b0);
    chk("valid_cleared_after_accept", out_valid, 0);
    chk("stage_clear_one_cycle", clr_pulses, 1);

    // Every other cycle: 8 enables per window, no drop; |most negative| maps cleanly.
    do_reset();
    rdy       = 1'b1;
    en_pulses = 0;
    expect_result(33'h0_8000_0000, MinV, 32'sd0);
    window(MinV, 32'sd0, 1, 1'b0);
    chk("enable_pulses_per_window", en_pulses, 8);
    wait_out("wait_min_zero", 8);
    chk("no_drop_sparse", drop, 0);

    expect_result(33'h0_C000_0000, MinV, MinV);
    window(MinV, MinV, 0, 1'b0);
    wait_out("wait_min_min", 8);

    // Consumer stalled across two windows: second result replaces the first.
    step(1'b0);
    rdy = 1'b0;
    window(32'sd10, 32'sd20, 0, 1'b0);
    expect_result(33'd8, -32'sd7, 32'sd3);
    window(-32'sd7, 32'sd3, 0, 1'b0);
    step(1'b0);
    step(1'b0);
    chk("overrun_before_overwrite", overrun, 0);
    chk("first_result_held", out_mag, 25);
    step(1'b0);
    chk("overrun_after_overwrite", overrun, 1);
    chk("valid_after_overwrite", out_valid, 1);
    rdy = 1'b1;
    step(1'b0);

    // Accept on the same edge a new result loads.
    do_reset();
    expect_result(33'd8, 32'sd5, -32'sd6);
    window(32'sd5, -32'sd6, 0, 1'b0);
    expect_result(33'd100, 32'sd100, 32'sd1);
    window(32'sd100, 32'sd1, 0, 1'b0);
    step(1'b0);
    rdy = 1'b1;
    step(1'b0);
    rdy = 1'b0;
    step(1'b0);
    chk("valid_after_accept_on_load", out_valid, 1);
    chk("no_overrun_accept_on_load", overrun, 0);
    rdy = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("valid_cleared_second", out_valid, 0);

    // Reset mid-window at count 5: next window needs 8 fresh samples.
    repeat (5) step(1'b1);
    do_reset();
    rdy        = 1'b1;
    en_pulses  = 0;
    clr_pulses = 0;
    repeat (7) step(1'b1);
    repeat (4) step(1'b0);
    chk("no_capture_after_7", clr_pulses, 0);
    chk("no_valid_from_aborted", out_valid, 0);
    acc_i = 32'sd40;
    acc_q = -32'sd9;
    expect_result(33'd44, 32'sd40, -32'sd9);
    step(1'b1);
    step(1'b0);
    chk("capture_after_8th", clr_pulses, 1);
    wait_out("wait_after_reset", 8);

    repeat (3) step(1'b0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
